mul_sequencer: RTL and testbench

Multi-cycle shift-add multiply controller for the mini ALU. It replaces the single-cycle combinational multiply paths (MUL/SMUL/LMUL) with a sequenced 16-iteration datapath. On a start request it stalls instruction fetch, iterates, and applies sign correction. It then issues one-cycle RAM write strobes for the low word and, for long multiplies, the high word.

---
 rtl/mul_sequencer_pkg.sv | 14 +
 rtl/mul_seq_datapath.sv | 88 ++++++++
 rtl/mul_sequencer.sv | 102 ++++++++++
 tb/tb_mul_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the sequenced shift-add multiplier: state encoding
// and default operand width.
package mul_sequencer_pkg;

  localparam int unsigned MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : mul_sequencer_pkg

// File: rtl/mul_seq_datapath.sv
// Shift-add datapath: operand magnitude capture, WIDTH accumulate steps,
// sign fix-up and the registered product.
import mul_sequencer_pkg::*;

module mul_seq_datapath #(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             fix_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic [WIDTH-1:0] result_hi_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    res_q, res_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Magnitudes; the most negative value maps onto its unsigned equivalent.
  assign a_neg = signed_i & op_a_i[WIDTH-1];
  assign b_neg = signed_i & op_b_i[WIDTH-1];
  assign a_mag = a_neg ? (~op_a_i + WIDTH'(1)) : op_a_i;
  assign b_mag = b_neg ? (~op_b_i + WIDTH'(1)) : op_b_i;

  assign last_o = (count_q == CW'(WIDTH - 1));

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    res_d    = res_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {WIDTH'(0), a_mag};
      mplier_d = b_mag;
      count_d  = '0;
      neg_d    = a_neg ^ b_neg;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
    end else if (fix_i) begin
      res_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      res_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      res_q    <= res_d;
    end
  end

  assign result_lo_o = res_q[WIDTH-1:0];
  assign result_hi_o = res_q[PW-1:WIDTH];

endmodule : mul_seq_datapath

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller: FSM, fetch stall and RAM write strobes
// around the shift-add datapath.
import mul_sequencer_pkg::*;

module mul_sequencer #(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iSigned,
  input  logic             iLong,
  input  logic [WIDTH-1:0] iOperandA,
  input  logic [WIDTH-1:0] iOperandB,
  output logic             oBusy,
  output logic             oStall,
  output logic             oDone,
  output logic             oWriteLo,
  output logic             oWriteHi,
  output logic [WIDTH-1:0] oResultLo,
  output logic [WIDTH-1:0] oResultHi
);

  state_e state_q;
  logic   long_q;
  logic   done_q;
  logic   wr_lo_q;
  logic   wr_hi_q;

  logic   load;
  logic   step;
  logic   fix;
  logic   last;

  assign load = (state_q == ST_IDLE) & iStart;
  assign step = (state_q == ST_RUN);
  assign fix  = (state_q == ST_FIX);

  // Strobes are registered on the FIX->DONE edge so they cover exactly DONE.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      long_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_lo_q <= 1'b0;
      wr_hi_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_lo_q <= 1'b0;
      wr_hi_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            state_q <= ST_RUN;
            long_q  <= iLong;
          end
        end
        ST_RUN: begin
          if (last) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          wr_lo_q <= 1'b1;
          wr_hi_q <= long_q;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mul_seq_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk_i       (Clock),
    .rst_ni      (Reset),
    .load_i      (load),
    .step_i      (step),
    .fix_i       (fix),
    .signed_i    (iSigned),
    .op_a_i      (iOperandA),
    .op_b_i      (iOperandB),
    .last_o      (last),
    .result_lo_o (oResultLo),
    .result_hi_o (oResultHi)
  );

  // Stall drops in DONE so fetch resumes while the write completes.
  assign oBusy    = (state_q != ST_IDLE);
  assign oStall   = load | step | fix;
  assign oDone    = done_q;
  assign oWriteLo = wr_lo_q;
  assign oWriteHi = wr_hi_q;

endmodule : mul_sequencer

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a product scoreboard.
module tb_mul_sequencer;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic        iSigned;
  logic        iLong;
  logic [15:0] iOperandA;
  logic [15:0] iOperandB;
  logic        oBusy;
  logic        oStall;
  logic        oDone;
  logic        oWriteLo;
  logic        oWriteHi;
  logic [15:0] oResultLo;
  logic [15:0] oResultHi;

  mul_sequencer #(.WIDTH(16)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iSigned   (iSigned),
    .iLong     (iLong),
    .iOperandA (iOperandA),
    .iOperandB (iOperandB),
    .oBusy     (oBusy),
    .oStall    (oStall),
    .oDone     (oDone),
    .oWriteLo  (oWriteLo),
    .oWriteHi  (oWriteHi),
    .oResultLo (oResultLo),
    .oResultHi (oResultHi)
  );

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        lg;
    logic        chk_hi;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] model_hi = '0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference product from plain 32-bit arithmetic.
  task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                          input logic sg, input logic lg);
    logic [31:0] p;
    exp_t        e;
    if (sg) p = 32'($signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b}));
    else    p = {16'h0, a} * {16'h0, b};
    e.lo     = p[15:0];
    e.hi     = p[31:16];
    e.lg     = lg;
    e.chk_hi = lg || (p[31:16] == model_hi);
    model_hi = p[31:16];
    sb.push_back(e);
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_lo"}, 32'(oResultLo), 32'(e.lo));
      if (e.chk_hi) check({tag, "_hi"}, 32'(oResultHi), 32'(e.hi));
      check({tag, "_wr_lo"}, 32'(oWriteLo), 32'd1);
      check({tag, "_wr_hi"}, 32'(oWriteHi), 32'(e.lg));
      check({tag, "_stall_done"}, 32'(oStall), 32'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sg, input logic lg);
    int lat;
    int seq_err;
    push_exp(a, b, sg, lg);
    iOperandA = a;
    iOperandB = b;
    iSigned   = sg;
    iLong     = lg;
    iStart    = 1'b1;
    #1;
    check({tag, "_stall_start"}, 32'(oStall), 32'd1);
    lat     = 0;
    seq_err = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        iStart    = 1'b0;
        iOperandA = 16'($urandom);
        iOperandB = 16'($urandom);
        iSigned   = 1'($urandom);
        iLong     = 1'($urandom);
      end
      if (oDone !== 1'b1) begin
        if (oStall !== 1'b1 || oBusy !== 1'b1 || oWriteLo !== 1'b0 || oWriteHi !== 1'b0)
          seq_err++;
      end
    end while (oDone !== 1'b1 && lat < 40);
    check({tag, "_latency"}, 32'(lat), 32'd18);
    check_result(tag);
    check({tag, "_busy_done"}, 32'(oBusy), 32'd1);
    check({tag, "_run_seq"}, 32'(seq_err), 32'd0);
    tick();
    check({tag, "_after"}, 32'({oDone, oWriteLo, oWriteHi, oBusy, oStall}), 32'd0);
  endtask

  initial begin
    int   stall_err;
    int   done_err;
    int   idle_err;
    int   n_done;
    logic exp_stall;
    logic exp_done;

    Reset     = 1'b0;
    iStart    = 1'b0;
    iSigned   = 1'b0;
    iLong     = 1'b0;
    iOperandA = '0;
    iOperandB = '0;
    tick();
    tick();
    check("rst_outputs", 32'({oBusy, oStall, oDone, oWriteLo, oWriteHi}), 32'd0);
    check("rst_lo", 32'(oResultLo), 32'd0);
    check("rst_hi", 32'(oResultHi), 32'd0);
    Reset = 1'b1;
    tick();
    check("idle_outputs", 32'({oBusy, oStall, oDone, oWriteLo, oWriteHi}), 32'd0);

    run_op("u3x5",      16'h0003, 16'h0005, 1'b0, 1'b0);
    run_op("sm3x5",     16'hFFFD, 16'h0005, 1'b1, 1'b1);
    run_op("s8000sq",   16'h8000, 16'h8000, 1'b1, 1'b1);
    run_op("uffffsq",   16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    run_op("s0x8000",   16'h0000, 16'h8000, 1'b1, 1'b1);
    run_op("s7fffx8000", 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    end

    // iStart held high: second op must begin from the IDLE cycle after DONE.
    push_exp(16'h1234, 16'h5678, 1'b0, 1'b1);
    push_exp(16'h1234, 16'h5678, 1'b0, 1'b1);
    iOperandA = 16'h1234;
    iOperandB = 16'h5678;
    iSigned   = 1'b0;
    iLong     = 1'b1;
    iStart    = 1'b1;
    stall_err = 0;
    done_err  = 0;
    n_done    = 0;
    for (int k = 0; k < 46; k++) begin
      tick();
      exp_stall = (k <= 16) || (k >= 18 && k <= 35);
      exp_done  = (k == 17) || (k == 36);
      if (oStall !== exp_stall) stall_err++;
      if (oDone !== exp_done) done_err++;
      if (oDone === 1'b1) begin
        n_done++;
        check_result("held");
      end
      if (k == 28) iStart = 1'b0;
    end
    check("held_stall_pattern", 32'(stall_err), 32'd0);
    check("held_done_pattern", 32'(done_err), 32'd0);
    check("held_done_count", 32'(n_done), 32'd2);

    // Reset mid-run at count = 7 aborts without any write.
    iOperandA = 16'h00FF;
    iOperandB = 16'h0101;
    iSigned   = 1'b0;
    iLong     = 1'b1;
    iStart    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) iStart = 1'b0;
    end
    check("pre_abort_busy", 32'(oBusy), 32'd1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    check("abort_outputs", 32'({oBusy, oStall, oDone, oWriteLo, oWriteHi}), 32'd0);
    check("abort_lo", 32'(oResultLo), 32'd0);
    check("abort_hi", 32'(oResultHi), 32'd0);
    model_hi = '0;
    idle_err = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (oDone !== 1'b0 || oWriteLo !== 1'b0 || oWriteHi !== 1'b0 || oBusy !== 1'b0)
        idle_err++;
    end
    check("abort_no_write", 32'(idle_err), 32'd0);

    run_op("u7x9", 16'd7, 16'd9, 1'b0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mul_sequencer
